// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types: datapath width, canonical NOP, fetch FSM states, buffer entry.
// Pure declarations; no timing or flow-control behaviour of its own.
package if_stage_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_ent_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch stage bus bundle: imem request/response, redirect and decode handoff.
// master = fetch stage side; slave = memory/decode/branch side.
interface if_stage_if;
    import if_stage_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc,
        input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc,
        output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_stage_fetch_skid_buf.sv
// Two-entry in-order instruction buffer (output register + skid); head is the oldest entry.
// Push/pop take effect at the clock edge; caller never pushes into a full buffer without a pop.
module fetch_skid_buf
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  fetch_ent_t push_dat,
    input  logic       pop,
    input  logic       flush,
    output logic [1:0] occ,
    output fetch_ent_t head
);

    fetch_ent_t ent0;
    fetch_ent_t ent1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ  <= 2'd0;
            ent0 <= {RV_NOP, RESET_PC};
            ent1 <= {RV_NOP, RESET_PC};
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) ent0 <= push_dat;
                    else             ent1 <= push_dat;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Simultaneous drain and fill: occupancy unchanged, skid entry advances first.
                    if (occ == 2'd1) begin
                        ent0 <= push_dat;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_dat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = ent0;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: single-outstanding imem requests, PC sequencing, redirect flush.
// Request issues combinationally; response lands in id_* next cycle; stalls when the buffer would overflow.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    if_stage_if.master    bus
);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;
    logic [1:0]      occ;
    logic [1:0]      occ_next;
    fetch_ent_t      head;
    fetch_ent_t      push_dat;
    logic            push;
    logic            pop;
    logic            req;
    logic            resp_slot;

    assign pop       = (occ != 2'd0) && bus.id_ready;
    assign push      = (state == WAIT) && bus.imem_rvalid && !bus.redirect_valid;
    assign occ_next  = occ + {1'b0, push} - {1'b0, pop};
    // A new request may go out when nothing is in flight or the in-flight one returns this cycle.
    assign resp_slot = (state == IDLE) || (state != IDLE && bus.imem_rvalid);
    assign req       = rst_n && !bus.redirect_valid && resp_slot && (occ_next <= 2'd1);

    assign push_dat.instr = bus.imem_rdata;
    assign push_dat.pc    = req_pc_q;

    always_comb begin
        state_nxt = state;
        if (bus.redirect_valid) begin
            case (state)
                WAIT:    state_nxt = bus.imem_rvalid ? IDLE : DROP;
                // A stale response landing with the redirect retires the DROP.
                DROP:    state_nxt = bus.imem_rvalid ? IDLE : DROP;
                default: state_nxt = IDLE;
            endcase
        end else begin
            case (state)
                IDLE:    state_nxt = req ? WAIT : IDLE;
                WAIT,
                DROP:    if (bus.imem_rvalid) state_nxt = req ? WAIT : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (bus.redirect_valid) begin
                pc_q <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            end else if (req) begin
                pc_q     <= pc_q + 32'd4;
                req_pc_q <= pc_q;
            end
        end
    end

    fetch_skid_buf #(.RESET_PC(RESET_PC)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (bus.redirect_valid),
        .occ      (occ),
        .head     (head)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = (occ != 2'd0);
    assign bus.id_instr  = head.instr;
    assign bus.id_pc     = head.pc;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural fixed-latency instruction memory.
module tb_if_stage;
    import if_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_stage_if bus();

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int lat    = 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0080_af03;
            32'h0000_0004: mem_word = 32'hff80_af03;
            32'h0000_0008: mem_word = 32'h0200_a283;
            default:       mem_word = a ^ 32'h1357_0000;
        endcase
    endfunction

    // Memory model: request seen mid-cycle, response `lat` cycles after issue.
    logic        req_now;
    logic [31:0] addr_now;
    logic        pend;
    logic [31:0] paddr;
    int          cnt;

    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        pend = 1'b0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            req_now  = bus.imem_req;
            addr_now = bus.imem_addr;
            @(posedge clk);
            #2;
            bus.imem_rvalid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else begin
                if (req_now) begin
                    pend  = 1'b1;
                    paddr = addr_now;
                    cnt   = lat;
                end
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.imem_rvalid = 1'b1;
                        bus.imem_rdata  = mem_word(paddr);
                        pend = 1'b0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        rst_n              = 1'b0;
        lat                = l;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
        check("rst_id_instr", bus.id_instr, 32'h0000_0013);
        check("rst_id_pc",    bus.id_pc,    32'h0000_0000);
        check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.id_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [31:0] exp_i [3];
    logic [31:0] exp_p [3];

    initial begin
        bit seen;
        rst_n = 1'b0;
        exp_i[0] = 32'h0080_af03; exp_p[0] = 32'h0;
        exp_i[1] = 32'hff80_af03; exp_p[1] = 32'h4;
        exp_i[2] = 32'h0200_a283; exp_p[2] = 32'h8;

        // Streaming fetch, 1-cycle memory
        do_reset(1);
        @(negedge clk);
        check("first_req",  {31'd0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr, 32'h0000_0000);
        wait_valid("stream");
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check("stream_valid", {31'd0, bus.id_valid}, 32'd1);
            check("stream_instr", bus.id_instr, exp_i[k]);
            check("stream_pc",    bus.id_pc,    exp_p[k]);
        end

        // Decode stall: buffer fills, fetch stops, order preserved on release
        do_reset(1);
        bus.id_ready = 1'b0;
        wait_valid("stall");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("stall_instr", bus.id_instr, 32'h0080_af03);
            check("stall_pc",    bus.id_pc,    32'h0);
        end
        check("stall_noreq", {31'd0, bus.imem_req}, 32'd0);
        tick();
        bus.id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("release_valid", {31'd0, bus.id_valid}, 32'd1);
            check("release_instr", bus.id_instr, exp_i[k]);
            check("release_pc",    bus.id_pc,    exp_p[k]);
        end

        // Redirect with request outstanding, 3-cycle memory
        do_reset(3);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_007c;
        @(negedge clk);
        check("redir_noreq", {31'd0, bus.imem_req}, 32'd0);
        tick();
        bus.redirect_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("redir_req_timeout", 32'd0, 32'd1);
        check("redir_addr", bus.imem_addr, 32'h0000_007c);
        wait_valid("redir");
        check("redir_instr", bus.id_instr, 32'h1357_007c);
        check("redir_pc",    bus.id_pc,    32'h0000_007c);

        // Redirect coincident with response, unaligned target
        do_reset(1);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0062;
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("align_req",   {31'd0, bus.imem_req}, 32'd1);
        check("align_addr",  bus.imem_addr, 32'h0000_0060);
        check("align_flush", {31'd0, bus.id_valid}, 32'd0);
        wait_valid("align");
        check("align_instr", bus.id_instr, 32'h1357_0060);
        check("align_pc",    bus.id_pc,    32'h0000_0060);

        // PC wrap at top of address space
        do_reset(1);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hffff_fffc;
        tick();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_addr0", bus.imem_addr, 32'hffff_fffc);
        @(negedge clk);
        check("wrap_req1",  {31'd0, bus.imem_req}, 32'd1);
        check("wrap_addr1", bus.imem_addr, 32'h0000_0000);
        wait_valid("wrap");
        check("wrap_instr", bus.id_instr, 32'heca8_fffc);
        check("wrap_pc",    bus.id_pc,    32'hffff_fffc);

        // Reset pulse mid-fetch at pc 0x10
        do_reset(1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr == 32'h10) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("midrst_timeout", 32'd0, 32'd1);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", {31'd0, bus.id_valid}, 32'd0);
        check("midrst_instr", bus.id_instr, 32'h0000_0013);
        check("midrst_req",   {31'd0, bus.imem_req}, 32'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_req2",  {31'd0, bus.imem_req}, 32'd1);
        check("midrst_addr",  bus.imem_addr, 32'h0000_0000);
        wait_valid("midrst");
        check("midrst_instr2", bus.id_instr, 32'h0080_af03);
        check("midrst_pc2",    bus.id_pc,    32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
